clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows.
REQ-002 Parameter DIV_WIDTH, default 8: width of the divisor value and the period counter.
REQ-003 Parameter RESET_DIV, default 2: divisor in effect after reset; legal range is 2..2^DIV_WIDTH-1.
REQ-004 Port clk_in, input, 1 bit: the only clock; all flops are rising-edge triggered.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port en, input, 1 bit: run request for the divided clock.
REQ-007 Port div_val, input, DIV_WIDTH bits: requested divisor N.
REQ-008 Port div_load, input, 1 bit: single-cycle strobe that captures div_val.
REQ-009 Port clk_out, output, 1 bit: divided clock, driven directly from a flop.
REQ-010 Port busy, output, 1 bit: high while a loaded divisor is waiting to be applied.
REQ-011 Port div_err, output, 1 bit: sticky flag, set when an illegal divisor is loaded.
REQ-012 Port running, output, 1 bit: high in the RUNNING and DRAINING states.

Function
REQ-013 States SHALL be STOPPED, RUNNING and DRAINING, with the following transitions:
- STOPPED to RUNNING when en=1.
- RUNNING to DRAINING when en=0.
- DRAINING to RUNNING when en=1 (the stop is cancelled and the period is not disturbed).
- DRAINING to STOPPED at the period boundary.
REQ-014 Counter cnt SHALL count 0..cur_div-1 and wrap to 0; the period boundary is the edge where cnt==cur_div-1.
REQ-015 High time: hi=ceil(cur_div/2); clk_out is high for hi clk_in cycles and low for cur_div-hi cycles (odd N: high phase is one cycle longer).
REQ-016 Start from STOPPED with en=1 sampled: at that edge cnt<=0 and clk_out<=1, so the first high phase is a full hi cycles.
REQ-017 In RUNNING and DRAINING, clk_out SHALL be registered as (next cnt < hi); there are no combinational paths to clk_out.
REQ-018 In STOPPED, clk_out=0 and cnt=0; a stop never truncates a high or low phase.
REQ-019 div_load in RUNNING or DRAINING SHALL write div_val into pend_div and set busy.
REQ-020 At the period boundary with busy=1, cur_div<=pend_div and busy<=0; the next period uses the new N.
REQ-021 div_load in STOPPED SHALL update cur_div at that edge; busy stays 0.
REQ-022 Repeated div_load before a boundary SHALL overwrite pend_div; the last value wins.
REQ-023 div_load on the boundary edge SHALL:
- apply any previous pend_div at that edge, and
- capture the new value as pending for the following boundary.
REQ-024 div_val<2 on div_load SHALL be replaced by 2 and SHALL set div_err, which is held until reset.
REQ-025 Counter and compare arithmetic SHALL be DIV_WIDTH bits wide; N=2^DIV_WIDTH-1 SHALL work without overflow.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL load:
- state=STOPPED, cnt=0, cur_div=RESET_DIV, pend_div=RESET_DIV;
- clk_out=0, busy=0, div_err=0, running=0.
REQ-027 rst asserted mid-period SHALL force clk_out=0 at that edge (the truncated phase is accepted); rst has priority over en and div_load.

Configuration
REQ-028 Macro CLK_DIV_PROG_TICK_EN SHALL control a tick output:
- Defined: adds output port tick, 1 bit. tick is high for exactly one clk_in cycle, in the same cycle clk_out rises. It is 0 in STOPPED and during reset.
- Undefined: the tick port and its logic are absent; all other behaviour is identical.

Verification
REQ-029 Reset with RESET_DIV=2, then en=1 -> clk_out pattern 1,0,1,0,...; running=1 one cycle after en is sampled.
REQ-030 div_load with div_val=5 in STOPPED, then en=1 -> clk_out repeats 1,1,1,0,0; period is 5 cycles.
REQ-031 Running at N=4, div_load with 7 in cycle 1 of a period -> busy=1 until the boundary; next period is 4 high / 3 low; busy=0 after the boundary.
REQ-032 Running at N=6, en=0 during a high phase -> the period completes (3 high, 3 low), then STOPPED with clk_out=0. Repeat with en re-raised before the boundary -> no gap in clk_out.
REQ-033 div_load with div_val=0, then div_val=1 -> effective N=2 and div_err=1, held across a later legal load until rst.
REQ-034 DIV_WIDTH=4, N=15, with CLK_DIV_PROG_TICK_EN defined -> 8 high / 7 low, and one tick per 15 cycles, aligned to the clk_out rise.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free start/stop and period-aligned divisor updates.
// Optional tick output enabled by defining CLK_DIV_PROG_TICK_EN.
module clk_div_prog #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic                 div_load,
  output logic                 clk_out,
  output logic                 busy,
  output logic                 div_err,
`ifdef CLK_DIV_PROG_TICK_EN
  output logic                 tick,
`endif
  output logic                 running
);

  typedef enum logic [1:0] {StStopped, StRunning, StDraining} state_e;

  localparam logic [DIV_WIDTH-1:0] ResetDiv = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] DivOne   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DivTwo   = DIV_WIDTH'(2);

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   cur_div_q, cur_div_d;
  logic [DIV_WIDTH-1:0]   pend_div_q, pend_div_d;
  logic                   clk_out_q, clk_out_d;
  logic                   busy_q, busy_d;
  logic                   div_err_q, div_err_d;

  logic [DIV_WIDTH-1:0]   load_val;
  logic                   load_bad;
  logic [DIV_WIDTH-1:0]   hi;
  logic                   boundary;
  logic [DIV_WIDTH-1:0]   cnt_inc;

  always_comb begin
    load_bad = div_load && (div_val < DivTwo);
    load_val = (div_val < DivTwo) ? DivTwo : div_val;
    // ceil(N/2) without widening: N>>1 plus the LSB fits in DIV_WIDTH bits for any legal N
    hi       = (cur_div_q >> 1) + {{(DIV_WIDTH-1){1'b0}}, cur_div_q[0]};
    boundary = (state_q != StStopped) && (cnt_q == (cur_div_q - DivOne));
    cnt_inc  = boundary ? '0 : (cnt_q + DivOne);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    busy_d     = busy_q;
    div_err_d  = div_err_q | load_bad;

    unique case (state_q)
      StStopped: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        // A value captured on the final draining boundary is applied here
        if (busy_q) begin
          cur_div_d = pend_div_q;
          busy_d    = 1'b0;
        end
        if (div_load) cur_div_d = load_val;
        if (en) begin
          state_d   = StRunning;
          clk_out_d = 1'b1;
        end
      end
      StRunning: begin
        cnt_d     = cnt_inc;
        clk_out_d = (cnt_inc < hi);
        if (!en) state_d = StDraining;
      end
      StDraining: begin
        cnt_d     = cnt_inc;
        clk_out_d = (cnt_inc < hi);
        if (en) begin
          state_d = StRunning;
        end else if (boundary) begin
          state_d   = StStopped;
          cnt_d     = '0;
          clk_out_d = 1'b0;
        end
      end
      default: begin
        state_d   = StStopped;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase

    if (state_q != StStopped) begin
      if (boundary && busy_q) begin
        cur_div_d = pend_div_q;
        busy_d    = 1'b0;
      end
      if (div_load) begin
        pend_div_d = load_val;
        busy_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= StStopped;
      cnt_q      <= '0;
      cur_div_q  <= ResetDiv;
      pend_div_q <= ResetDiv;
      clk_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      clk_out_q  <= clk_out_d;
      busy_q     <= busy_d;
      div_err_q  <= div_err_d;
    end
  end

`ifdef CLK_DIV_PROG_TICK_EN
  logic tick_q;

  // Registered rise detect lines up with the cycle in which clk_out goes high
  always_ff @(posedge clk_in) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= clk_out_d & ~clk_out_q;
  end

  assign tick = tick_q;
`endif

  assign clk_out = clk_out_q;
  assign busy    = busy_q;
  assign div_err = div_err_q;
  assign running = (state_q != StStopped);

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog: an 8-bit instance for most vectors and a
// 4-bit instance for the N=15 full-range case (tick checked when CLK_DIV_PROG_TICK_EN is defined).
module tb_clk_div_prog;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, div_load;
  logic [7:0] div_val;
  logic       clk_out, busy, div_err, running;

  logic       en4, load4;
  logic [3:0] val4;
  logic       clk_out4, busy4, err4, running4;

`ifdef CLK_DIV_PROG_TICK_EN
  logic       tick_m, tick4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  clk_div_prog #(.DIV_WIDTH(8), .RESET_DIV(2)) dut (
    .clk_in  (clk),
    .rst     (rst),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .clk_out (clk_out),
    .busy    (busy),
    .div_err (div_err),
`ifdef CLK_DIV_PROG_TICK_EN
    .tick    (tick_m),
`endif
    .running (running)
  );

  clk_div_prog #(.DIV_WIDTH(4), .RESET_DIV(2)) dut4 (
    .clk_in  (clk),
    .rst     (rst),
    .en      (en4),
    .div_val (val4),
    .div_load(load4),
    .clk_out (clk_out4),
    .busy    (busy4),
    .div_err (err4),
`ifdef CLK_DIV_PROG_TICK_EN
    .tick    (tick4),
`endif
    .running (running4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample clk_out over n cycles against pat, MSB first
  task automatic run_pattern(input string tag, input int n, input logic [63:0] pat);
    for (int i = 0; i < n; i++) begin
      step();
      check_eq($sformatf("%s[%0d]", tag, i), 32'(clk_out), 32'(pat[n-1-i]));
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    en       = 1'b0;
    div_load = 1'b0;
    step();
    rst      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
    en4 = 1'b0; load4 = 1'b0; val4 = '0;
    step();
    step();
    check_eq("rst_clk_out", 32'(clk_out), 32'd0);
    check_eq("rst_busy",    32'(busy),    32'd0);
    check_eq("rst_err",     32'(div_err), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);

    // N=2 from reset
    rst = 1'b0;
    en  = 1'b1;
    step();
    check_eq("n2_running", 32'(running), 32'd1);
    check_eq("n2_first",   32'(clk_out), 32'd1);
`ifdef CLK_DIV_PROG_TICK_EN
    check_eq("n2_tick", 32'(tick_m), 32'd1);
`endif
    run_pattern("n2", 7, 64'b0101010);

    // Load 5 while stopped
    do_reset();
    div_load = 1'b1; div_val = 8'd5;
    step();
    div_load = 1'b0;
    check_eq("n5_busy_stopped", 32'(busy),    32'd0);
    check_eq("n5_clk_stopped",  32'(clk_out), 32'd0);
    check_eq("n5_run_stopped",  32'(running), 32'd0);
    en = 1'b1;
    run_pattern("n5", 10, 64'b1110011100);

    // N=4, load 7 in cycle 1 of a period
    do_reset();
    div_load = 1'b1; div_val = 8'd4;
    step();
    div_load = 1'b0;
    en = 1'b1;
    run_pattern("n4", 2, 64'b11);
    div_load = 1'b1; div_val = 8'd7;
    step();
    div_load = 1'b0;
    check_eq("n4_busy_a", 32'(busy),    32'd1);
    check_eq("n4_clk_a",  32'(clk_out), 32'd0);
    step();
    check_eq("n4_busy_b", 32'(busy),    32'd1);
    check_eq("n4_clk_b",  32'(clk_out), 32'd0);
    run_pattern("n7", 8, 64'b11110001);
    check_eq("n7_busy", 32'(busy), 32'd0);

    // Reset in a high phase wins over en and div_load
    rst = 1'b1; en = 1'b1; div_load = 1'b1; div_val = 8'd9;
    step();
    check_eq("midrst_clk",  32'(clk_out), 32'd0);
    check_eq("midrst_run",  32'(running), 32'd0);
    check_eq("midrst_busy", 32'(busy),    32'd0);
    rst = 1'b0; en = 1'b0; div_load = 1'b0;
    step();
    check_eq("midrst_idle", 32'(clk_out), 32'd0);
    en = 1'b1;
    run_pattern("postrst_n2", 4, 64'b1010);

    // N=6: drain, then drain cancelled
    do_reset();
    div_load = 1'b1; div_val = 8'd6;
    step();
    div_load = 1'b0;
    en = 1'b1;
    run_pattern("n6a", 2, 64'b11);
    en = 1'b0;
    run_pattern("drain", 4, 64'b1000);
    check_eq("drain_running", 32'(running), 32'd1);
    run_pattern("stopped", 2, 64'b00);
    check_eq("stopped_running", 32'(running), 32'd0);
    en = 1'b1;
    run_pattern("n6b", 2, 64'b11);
    en = 1'b0;
    run_pattern("pre_resume", 2, 64'b10);
    en = 1'b1;
    run_pattern("resume", 6, 64'b001110);
    check_eq("resume_running", 32'(running), 32'd1);

    // Illegal divisors, sticky error, load on a boundary edge
    do_reset();
    div_load = 1'b1; div_val = 8'd0;
    step();
    check_eq("err_after_0", 32'(div_err), 32'd1);
    div_val = 8'd1;
    step();
    div_load = 1'b0;
    check_eq("err_after_1", 32'(div_err), 32'd1);
    en = 1'b1;
    run_pattern("n2_err", 4, 64'b1010);
    div_load = 1'b1; div_val = 8'd3;
    step();
    div_load = 1'b0;
    check_eq("err_held",      32'(div_err), 32'd1);
    check_eq("bnd_load_busy", 32'(busy),    32'd1);
    check_eq("bnd_load_clk",  32'(clk_out), 32'd1);
    run_pattern("n3", 5, 64'b01101);
    check_eq("n3_busy", 32'(busy), 32'd0);
    do_reset();
    check_eq("err_cleared", 32'(div_err), 32'd0);

    // 4-bit instance at N=15
    load4 = 1'b1; val4 = 4'd15;
    step();
    load4 = 1'b0;
    check_eq("w4_busy_stopped", 32'(busy4), 32'd0);
    en4 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check_eq($sformatf("w4_clk[%0d]", i), 32'(clk_out4), 32'((i % 15) < 8));
`ifdef CLK_DIV_PROG_TICK_EN
      check_eq($sformatf("w4_tick[%0d]", i), 32'(tick4), 32'((i % 15) == 0));
`endif
    end
    check_eq("w4_running", 32'(running4), 32'd1);
    check_eq("w4_err",     32'(err4),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
